// File: rtl/apb_demux_n.sv
// rtl/apb_demux_n.sv - APB3 1-to-N demultiplexer with decode-error response and error counting
// Optional access timeout is enabled by defining APB_DEMUX_TIMEOUT_EN.
module apb_demux_n #(
  parameter int NUM_SLAVES  = 8,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int SEL_MSB     = 31,
  parameter int SEL_LSB     = 28,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  pclk_i,
  input  logic                  presetn_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_W-1:0]     paddr_i,
  input  logic [DATA_W-1:0]     pwdata_i,
  output logic [DATA_W-1:0]     prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [NUM_SLAVES-1:0] psel_o,
  output logic [NUM_SLAVES-1:0] penable_o,
  output logic [NUM_SLAVES-1:0] pwrite_o,
  output logic [ADDR_W-1:0]     paddr_o [NUM_SLAVES],
  output logic [DATA_W-1:0]     pwdata_o [NUM_SLAVES],
  input  logic [DATA_W-1:0]     prdata_i [NUM_SLAVES],
  input  logic [NUM_SLAVES-1:0] pready_i,
  input  logic [NUM_SLAVES-1:0] pslverr_i,
  output logic [7:0]            err_cnt_o,
  output logic [ADDR_W-1:0]     last_err_addr_o
);

  localparam int IDX_W = SEL_MSB - SEL_LSB + 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDX_W:0]   NUM_SLV  = (IDX_W + 1)'(NUM_SLAVES);
  localparam logic [CNT_W-1:0] TOUT_LIM = CNT_W'(TIMEOUT_CYC);
`ifdef APB_DEMUX_TIMEOUT_EN
  localparam bit TOUT_EN = 1'b1;
`else
  localparam bit TOUT_EN = 1'b0;
`endif

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, live_idx;
  logic              dec_err_q, live_dec_err, tout_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              sel_ready, sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              setup, err_done, stall;

  assign live_idx     = paddr_i[SEL_MSB:SEL_LSB];
  assign live_dec_err = {1'b0, live_idx} >= NUM_SLV;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_bcast
    assign paddr_o[k]  = paddr_i;
    assign pwdata_o[k] = pwdata_i;
  end
  assign pwrite_o = {NUM_SLAVES{pwrite_i}};

  // Response of the slave latched at setup; never indexed by live paddr_i.
  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ready = pready_i[k];
        sel_err   = pslverr_i[k];
        sel_rdata = prdata_i[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    psel_o    = '0;
    penable_o = '0;
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    case (state_q)
      S_IDLE: begin
        for (int k = 0; k < NUM_SLAVES; k++)
          psel_o[k] = psel_i && (live_idx == IDX_W'(k)) && !live_dec_err;
        if (psel_i && !penable_i) state_d = S_ACCESS;
      end
      S_ACCESS: begin
        for (int k = 0; k < NUM_SLAVES; k++)
          psel_o[k] = psel_i && (idx_q == IDX_W'(k)) && !dec_err_q && !tout_q;
        penable_o = psel_o & {NUM_SLAVES{penable_i}};
        if (dec_err_q || tout_q) begin
          pready_o  = 1'b1;
          pslverr_o = 1'b1;
        end else begin
          pready_o  = sel_ready;
          pslverr_o = sel_err;
          prdata_o  = pwrite_i ? '0 : sel_rdata;
        end
        if (!psel_i || pready_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign setup    = (state_q == S_IDLE) && psel_i && !penable_i;
  assign err_done = (state_q == S_ACCESS) && psel_i && (dec_err_q || tout_q);
  assign stall    = (state_q == S_ACCESS) && psel_i && penable_i &&
                    !dec_err_q && !tout_q && !sel_ready;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      dec_err_q       <= 1'b0;
      tout_q          <= 1'b0;
      cnt_q           <= '0;
      addr_q          <= '0;
      err_cnt_o       <= '0;
      last_err_addr_o <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        idx_q     <= live_idx;
        dec_err_q <= live_dec_err;
        addr_q    <= paddr_i;
        cnt_q     <= '0;
        tout_q    <= 1'b0;
      end else if (TOUT_EN && stall) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (cnt_q == TOUT_LIM - CNT_W'(1)) tout_q <= 1'b1;
      end
      if (err_done) begin
        if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        last_err_addr_o <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_apb_demux_n.sv
// tb/tb_apb_demux_n.sv - scoreboard bench for apb_demux_n (timeout cases need APB_DEMUX_TIMEOUT_EN)
module tb_apb_demux_n;
  localparam int NS = 6;
  localparam int TO = 16;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0, prdata;
  logic pready, pslverr;
  logic [NS-1:0] s_psel, s_penable, s_pwrite;
  logic [NS-1:0] s_pready = '1, s_pslverr = '0;
  logic [31:0] s_paddr [NS];
  logic [31:0] s_pwdata [NS];
  logic [31:0] s_prdata [NS];
  logic [7:0]  err_cnt;
  logic [31:0] last_err_addr;

  typedef struct {
    logic [31:0] rdata;
    logic        slverr;
    int          cycles;
    logic [7:0]  cnt;
    logic [31:0] last;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  logic [7:0]  m_cnt = '0;
  logic [31:0] m_last = '0;

  always #5 pclk = ~pclk;

  apb_demux_n #(.NUM_SLAVES(NS), .TIMEOUT_CYC(TO)) dut (
    .pclk_i(pclk), .presetn_i(presetn),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .psel_o(s_psel), .penable_o(s_penable), .pwrite_o(s_pwrite),
    .paddr_o(s_paddr), .pwdata_o(s_pwdata),
    .prdata_i(s_prdata), .pready_i(s_pready), .pslverr_i(s_pslverr),
    .err_cnt_o(err_cnt), .last_err_addr_o(last_err_addr)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // One transfer; starts and ends 1 time unit after a rising edge with psel still high.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall, input logic serr, input logic [31:0] rdata);
    int idx = int'(addr[31:28]);
    bit dec = (idx >= NS);
    bit tout = 1'b0;
    bit done = 1'b0;
    exp_t e;
    logic [NS-1:0] oh, exp_oh;
`ifdef APB_DEMUX_TIMEOUT_EN
    tout = !dec && (stall >= TO);
`endif
    oh = '0;
    if (!dec) oh[idx] = 1'b1;
    e.cycles = dec ? 1 : (tout ? TO + 1 : stall + 1);
    e.slverr = (dec || tout) ? 1'b1 : serr;
    e.rdata  = (dec || tout || wr) ? 32'h0 : rdata;
    if (dec || tout) begin
      if (m_cnt != 8'hFF) m_cnt++;
      m_last = addr;
    end
    e.cnt  = m_cnt;
    e.last = m_last;
    sb_q.push_back(e);

    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    if (!dec) begin
      s_pready[idx]  = (stall == 0);
      s_pslverr[idx] = serr;
      s_prdata[idx]  = rdata;
    end
    @(negedge pclk);
    check("setup_psel", 64'(s_psel), 64'(oh));
    check("setup_penable", 64'(s_penable), 64'(0));
    check("setup_pready", 64'(pready), 64'(0));
    check("bcast_pwrite", 64'(s_pwrite), 64'({NS{wr}}));
    check("bcast_pwdata", 64'(s_pwdata[NS-1]), 64'(wdata));
    @(posedge pclk); #1;
    penable = 1'b1;
    paddr = addr ^ 32'h1000_0000;
    for (int c = 1; c <= 60 && !done; c++) begin
      if (!dec) s_pready[idx] = (c > stall);
      @(negedge pclk);
      exp_oh = (tout && c > TO) ? '0 : oh;
      check("acc_psel", 64'(s_psel), 64'(exp_oh));
      check("acc_penable", 64'(s_penable), 64'(exp_oh));
      if (pready) begin
        e = sb_q.pop_front();
        check("prdata", 64'(prdata), 64'(e.rdata));
        check("pslverr", 64'(pslverr), 64'(e.slverr));
        check("access_cycles", 64'(c), 64'(e.cycles));
        done = 1'b1;
      end
      @(posedge pclk); #1;
    end
    if (!done) check("pready_never_seen", 64'(0), 64'(1));
    check("err_cnt", 64'(err_cnt), 64'(e.cnt));
    check("last_err_addr", 64'(last_err_addr), 64'(e.last));
  endtask

  task automatic idle(input int n);
    psel = 1'b0; penable = 1'b0;
    repeat (n) begin
      @(posedge pclk); #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NS; k++) s_prdata[k] = 32'h0;
    @(negedge pclk);
    check("rst_psel", 64'(s_psel), 64'(0));
    check("rst_pready", 64'(pready), 64'(0));
    check("rst_prdata", 64'(prdata), 64'(0));
    check("rst_err_cnt", 64'(err_cnt), 64'(0));
    check("rst_last_err", 64'(last_err_addr), 64'(0));
    @(posedge pclk); #1;
    presetn = 1'b1;
    idle(2);

    xfer(1'b1, 32'h2000_3000, 32'h55AA_AA55, 0, 1'b0, 32'h0);
    idle(1);
    xfer(1'b0, 32'h5000_0010, 32'h0, 0, 1'b0, 32'hCAFE_BEE5);
    idle(1);
    xfer(1'b0, 32'h7000_0020, 32'h0, 0, 1'b0, 32'h0);
    // Back-to-back, including the first unmapped index.
    xfer(1'b0, 32'h0000_0004, 32'h0, 0, 1'b0, 32'h1234_5678);
    xfer(1'b1, 32'h1000_0008, 32'hA5A5_0001, 1, 1'b0, 32'hDEAD_0000);
    xfer(1'b0, 32'h6000_0000, 32'h0, 0, 1'b0, 32'h0);
    xfer(1'b1, 32'h3000_0040, 32'h0BAD_F00D, 3, 1'b1, 32'h0);
    idle(1);
    xfer(1'b0, 32'h4000_0100, 32'h0, TO - 1, 1'b0, 32'h7777_8888);
    idle(1);
`ifdef APB_DEMUX_TIMEOUT_EN
    for (int n = 0; n < 256; n++) begin
      xfer(1'b1, 32'h4000_0001 + 32'(n), 32'hFFFF_0000, 1000, 1'b0, 32'h0);
      idle(1);
    end
    check("err_cnt_saturated", 64'(err_cnt), 64'(8'hFF));
`endif

    // Reset in the second access cycle of a stalled transfer to slave 1.
    s_pready[1] = 1'b0;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h1000_0000;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    check("pre_rst_penable", 64'(s_penable), 64'(6'b000010));
    presetn = 1'b0;
    #1;
    check("midrst_psel", 64'(s_psel), 64'(6'b000010));
    check("midrst_penable", 64'(s_penable), 64'(0));
    check("midrst_pready", 64'(pready), 64'(0));
    check("midrst_err_cnt", 64'(err_cnt), 64'(0));
    check("midrst_last_err", 64'(last_err_addr), 64'(0));
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    s_pready = '1;
    @(negedge pclk);
    check("post_rst_psel", 64'(s_psel), 64'(0));
    check("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_demux_n.md
# apb_demux_n

Parametrised APB3 1-to-N demultiplexer with registered slave selection, decode-error response and optional access timeout. Sits between one APB master and NUM_SLAVES APB slaves and routes each transfer by an address field. Unmapped addresses complete with PSLVERR instead of hanging the bus. Error events are counted for software visibility.

## Interface
- NUM_SLAVES, 8, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_MSB, 31, top bit of slave-index field in paddr_i
- SEL_LSB, 28, bottom bit of slave-index field; 2^(SEL_MSB-SEL_LSB+1) >= NUM_SLAVES
- TIMEOUT_CYC, 16, access cycles allowed with pready low before abort (>=1)

Ports:
- pclk_i  in  1  clock, all state on rising edge
- presetn_i  in  1  asynchronous active-low reset
- psel_i, penable_i, pwrite_i  in  1  master control
- paddr_i  in  ADDR_W  master address
- pwdata_i  in  DATA_W  master write data
- prdata_o  out  DATA_W  read data to master
- pready_o, pslverr_o  out  1  completion and error to master
- psel_o[NUM_SLAVES], penable_o[NUM_SLAVES], pwrite_o[NUM_SLAVES]  out  1  per-slave control
- paddr_o[NUM_SLAVES]  out  ADDR_W  per-slave address (broadcast of paddr_i)
- pwdata_o[NUM_SLAVES]  out  DATA_W  per-slave write data (broadcast of pwdata_i)
- prdata_i[NUM_SLAVES]  in  DATA_W, pready_i[NUM_SLAVES], pslverr_i[NUM_SLAVES]  in  1  slave responses
- err_cnt_o  out  8  saturating count of decode errors + timeouts
- last_err_addr_o  out  ADDR_W  paddr of most recent decode error/timeout

## Operation
- FSM: IDLE, ACCESS. IDLE with psel_i=1, penable_i=0 at edge -> ACCESS; latch idx_q = paddr_i[SEL_MSB:SEL_LSB], dec_err_q = (idx >= NUM_SLAVES), addr_q = paddr_i, cnt=0, tout_q=0.
- ACCESS -> IDLE on edge where pready_o=1, or where psel_i=0 (master abort; no counters updated).
- IDLE: psel_o[k] = psel_i & (k == live index) & !live decode error; all penable_o=0; pready_o=0, pslverr_o=0, prdata_o=0.
- ACCESS: psel_o[k] = psel_i & (k==idx_q) & !dec_err_q & !tout_q; penable_o[k] = psel_o[k] & penable_i.
- ACCESS, dec_err_q: pready_o=1, pslverr_o=1, prdata_o=0 in first access cycle; no slave selected.
- ACCESS, tout_q: pready_o=1, pslverr_o=1, prdata_o=0; selected slave already deselected, its response ignored.
- ACCESS otherwise: pready_o/pslverr_o/prdata_o = pready_i/pslverr_i/prdata_i[idx_q]; prdata_o forced 0 on writes.
- pwrite_o, paddr_o, pwdata_o broadcast to all slaves in every state.
- Slave-reported pslverr_i passed through; not counted.
- On decode error or timeout completion: err_cnt_o += 1, saturating at 255; last_err_addr_o = addr_q.
- Index decoded from live paddr_i only in the setup cycle; paddr_i changes during ACCESS do not re-route.

## Timing
- Reset (presetn_i=0, any time): state IDLE, idx_q=0, dec_err_q=0, tout_q=0, cnt=0, err_cnt_o=0, last_err_addr_o=0; pready_o=0, pslverr_o=0, prdata_o=0; psel_o/penable_o follow psel_i in IDLE (0 when psel_i=0). Reset mid-ACCESS drops the transfer; no error counted.
- Zero added latency: mapped transfer with pready_i=1 completes in 2 cycles (setup + access).
- Decode error: 2 cycles total.
- Back-to-back: new setup accepted in cycle after completion.
- Timeout: cnt increments each ACCESS cycle with penable_i=1 and selected pready_i=0; edge where cnt reaches TIMEOUT_CYC sets tout_q; master completes in access cycle TIMEOUT_CYC+1. pready_i arriving in cycle TIMEOUT_CYC completes normally (no timeout).
- Counter width clog2(TIMEOUT_CYC+1); no wrap.

## Configuration
- APB_DEMUX_TIMEOUT_EN defined: timeout counter, tout_q and timeout error counting present as above.
- Undefined: no counter; ACCESS waits indefinitely for pready_i; err_cnt_o/last_err_addr_o track decode errors only.

## Test plan
- Write 0x2000_3000 / 0x55AA_AA55, all pready_i=1 -> only psel_o[2] high, pwdata_o[2]=0x55AA_AA55, penable_o[2] in cycle 2, pready_o=1 cycle 2, err_cnt_o=0.
- Read 0x5000_0010, prdata_i[5]=0xCAFE_BEE5 -> prdata_o=0xCAFE_BEE5, pslverr_o=0, 2 cycles.
- NUM_SLAVES=6, read 0x7000_0020 -> no psel_o, pready_o=1, pslverr_o=1, prdata_o=0 in cycle 2; err_cnt_o=1, last_err_addr_o=0x7000_0020.
- pready_i[3]=0 for 3 access cycles, pslverr_i[3]=1 on completion -> access lasts 4 cycles, pslverr_o=1, err_cnt_o unchanged.
- With APB_DEMUX_TIMEOUT_EN, TIMEOUT_CYC=16, pready_i[4]=0 forever, write 0x4000_0001 -> psel_o[4] high 17 cycles then low; pready_o=pslverr_o=1 in access cycle 17; err_cnt_o +1; 256 timeouts -> err_cnt_o=255.
- presetn_i low in 2nd access cycle of stalled transfer to slave 1 -> psel_o[1]/penable_o[1] follow IDLE rules immediately, pready_o=0, err_cnt_o=0.
